ddr3_dqs_lane_delay_trainer: RTL and testbench

Per-lane read-DQS delay training controller for the DDR3 PHY block. It sits beside the lane DQS IOD, driving its dynamic delay-line controls (move, direction, load) and eye-monitor clear, and consuming the IOD's eye-monitor early/late flags and out-of-range indication. It sweeps the receive delay, finds the left and right edges of the valid window, then parks the delay line at the window centre and reports the result to the PHY training sequencer.

---
 rtl/ddr3_phy_train_pkg.sv | 25 ++
 rtl/ddr3_dqs_lane_delay_trainer_if.sv | 32 +++
 rtl/ddr3_eye_flag_accum.sv | 41 ++++
 rtl/ddr3_dqs_lane_delay_trainer.sv | 149 ++++++++++++++
 tb/tb_ddr3_dqs_lane_delay_trainer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_phy_train_pkg.sv
// rtl/ddr3_phy_train_pkg.sv - shared types and constants for PHY lane delay training
package ddr3_phy_train_pkg;

  localparam int TAP_W             = 8;
  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int SAMPLE_CYCLES_DEF = 32;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CLEAR,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CENTER_SETTLE,
    ST_CENTER_STEP,
    ST_DONE,
    ST_FAIL
  } train_state_t;

endpackage

// File: rtl/ddr3_dqs_lane_delay_trainer_if.sv
// rtl/ddr3_dqs_lane_delay_trainer_if.sv - IOD delay-line, eye-monitor and sequencer signals of one DQS lane
interface ddr3_dqs_lane_delay_trainer_if;
  import ddr3_phy_train_pkg::*;

  logic             start;
  logic             eye_monitor_early;
  logic             eye_monitor_late;
  logic             delay_line_out_of_range;
  logic             delay_line_load;
  logic             delay_line_move;
  logic             delay_line_direction;
  logic             eye_monitor_clear_flags;
  logic             busy;
  logic             done;
  logic             fail;
  logic [TAP_W-1:0] tap_left;
  logic [TAP_W-1:0] tap_right;
  logic [TAP_W-1:0] tap_center;

  modport master (
    input  start, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
    output delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
    output busy, done, fail, tap_left, tap_right, tap_center
  );

  modport slave (
    output start, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
    input  delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
    input  busy, done, fail, tap_left, tap_right, tap_center
  );

endinterface

// File: rtl/ddr3_eye_flag_accum.sv
// rtl/ddr3_eye_flag_accum.sv - OR-accumulates eye-monitor flags over a fixed window after start
module ddr3_eye_flag_accum #(
  parameter int SAMPLE_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flag,
  output logic done,
  output logic bad
);

  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          active;

  // done is high in the last window cycle; bad then includes that cycle's flag
  assign done = active && (cnt == CW'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      bad    <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
      bad    <= 1'b0;
    end else if (active) begin
      bad <= bad | flag;
      if (done) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_dqs_lane_delay_trainer.sv
// rtl/ddr3_dqs_lane_delay_trainer.sv - sweeps the lane read-DQS delay, finds the eye edges and parks at the centre
module ddr3_dqs_lane_delay_trainer
  import ddr3_phy_train_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
  parameter int MAX_TAP       = 255
) (
  input  logic fab_clk,
  input  logic arst,
  ddr3_dqs_lane_delay_trainer_if.master lane
);

  localparam int SCW = $clog2(SETTLE_CYCLES);

  train_state_t     state, state_nxt;
  logic [TAP_W-1:0] tap, tap_left_q, tap_right_q, tap_center_q;
  logic [TAP_W-1:0] left_sel, right_sel, center_calc;
  logic [TAP_W:0]   edge_sum;
  logic [SCW-1:0]   settle_cnt;
  logic             settle_last, found_left, oor_seen, go_center;
  logic             acc_start, acc_done, acc_bad;
  logic             load_q, move_q, dir_q, clear_q, busy_q, done_q, fail_q;

  assign settle_last = (settle_cnt == SCW'(SETTLE_CYCLES - 1));
  assign acc_start   = (state == ST_CLEAR);

  ddr3_eye_flag_accum #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_accum (
    .clk  (fab_clk),
    .rst  (arst),
    .start(acc_start),
    .flag (lane.eye_monitor_early | lane.eye_monitor_late),
    .done (acc_done),
    .bad  (acc_bad)
  );

  // Edge candidates as they would be latched by this EVAL; 9-bit sum keeps the floor exact
  always_comb begin
    left_sel    = found_left ? tap_left_q : tap;
    right_sel   = acc_bad ? tap - 1'b1 : tap;
    edge_sum    = {1'b0, left_sel} + {1'b0, right_sel};
    center_calc = edge_sum[TAP_W:1];
  end

  always_comb begin
    state_nxt = state;
    go_center = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: if (lane.start) state_nxt = ST_LOAD;
      ST_LOAD, ST_STEP:          state_nxt = ST_SETTLE;
      ST_SETTLE:                 if (settle_last) state_nxt = ST_CLEAR;
      ST_CLEAR:                  state_nxt = ST_SAMPLE;
      ST_SAMPLE:                 if (acc_done) state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (found_left && acc_bad) begin
          go_center = 1'b1;
        end else if ((tap == TAP_W'(MAX_TAP)) || oor_seen) begin
          if (found_left || !acc_bad) go_center = 1'b1;
          else                        state_nxt = ST_FAIL;
        end else begin
          state_nxt = ST_STEP;
        end
        if (go_center) state_nxt = (tap > center_calc) ? ST_CENTER_STEP : ST_DONE;
      end
      ST_CENTER_STEP:   state_nxt = ST_CENTER_SETTLE;
      ST_CENTER_SETTLE: if (settle_last) state_nxt = (tap > tap_center_q) ? ST_CENTER_STEP : ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge fab_clk or posedge arst) begin
    if (arst) begin
      state        <= ST_IDLE;
      tap          <= '0;
      tap_left_q   <= '0;
      tap_right_q  <= '0;
      tap_center_q <= '0;
      settle_cnt   <= '0;
      found_left   <= 1'b0;
      oor_seen     <= 1'b0;
      load_q       <= 1'b0;
      move_q       <= 1'b0;
      dir_q        <= 1'b0;
      clear_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == ST_SETTLE || state == ST_CENTER_SETTLE) && !settle_last)
        settle_cnt <= settle_cnt + 1'b1;
      else
        settle_cnt <= '0;

      case (state)
        ST_LOAD:        tap <= '0;
        ST_STEP:        tap <= tap + 1'b1;
        ST_CENTER_STEP: tap <= tap - 1'b1;
        default:        ;
      endcase

      // Cleared while the load/move is issued so only the new tap's range flag counts
      if (state == ST_LOAD || state == ST_STEP)
        oor_seen <= 1'b0;
      else if (lane.delay_line_out_of_range)
        oor_seen <= 1'b1;

      if (state_nxt == ST_LOAD) begin
        found_left   <= 1'b0;
        tap_left_q   <= '0;
        tap_right_q  <= '0;
        tap_center_q <= '0;
      end else if (state == ST_EVAL) begin
        if (!found_left && !acc_bad) begin
          found_left <= 1'b1;
          tap_left_q <= tap;
        end
        if (go_center) begin
          tap_right_q  <= right_sel;
          tap_center_q <= center_calc;
        end
      end

      load_q  <= (state_nxt == ST_LOAD);
      move_q  <= (state_nxt == ST_STEP) || (state_nxt == ST_CENTER_STEP);
      clear_q <= (state_nxt == ST_CLEAR);
      if (state_nxt == ST_STEP)             dir_q <= DIR_INC;
      else if (state_nxt == ST_CENTER_STEP) dir_q <= DIR_DEC;
      busy_q  <= !(state_nxt == ST_IDLE || state_nxt == ST_DONE || state_nxt == ST_FAIL);
      done_q  <= (state_nxt == ST_DONE);
      fail_q  <= (state_nxt == ST_FAIL);
    end
  end

  assign lane.delay_line_load         = load_q;
  assign lane.delay_line_move         = move_q;
  assign lane.delay_line_direction    = dir_q;
  assign lane.eye_monitor_clear_flags = clear_q;
  assign lane.busy                    = busy_q;
  assign lane.done                    = done_q;
  assign lane.fail                    = fail_q;
  assign lane.tap_left                = tap_left_q;
  assign lane.tap_right               = tap_right_q;
  assign lane.tap_center              = tap_center_q;

endmodule

// File: tb/tb_ddr3_dqs_lane_delay_trainer.sv
// tb/tb_ddr3_dqs_lane_delay_trainer.sv - randomized self-checking bench with an IOD model and eye reference model
module tb_ddr3_dqs_lane_delay_trainer;
  import ddr3_phy_train_pkg::*;

  localparam int TAP_COST  = 1 + SETTLE_CYCLES_DEF + 1 + SAMPLE_CYCLES_DEF + 1;
  localparam int BACK_COST = 1 + SETTLE_CYCLES_DEF;

  logic fab_clk = 1'b0;
  logic arst;

  ddr3_dqs_lane_delay_trainer_if lane ();

  ddr3_dqs_lane_delay_trainer #(
    .SETTLE_CYCLES(SETTLE_CYCLES_DEF),
    .SAMPLE_CYCLES(SAMPLE_CYCLES_DEF),
    .MAX_TAP      (255)
  ) dut (
    .fab_clk(fab_clk),
    .arst   (arst),
    .lane   (lane)
  );

  always #5 fab_clk = ~fab_clk;

  int checks   = 0;
  int failures = 0;

  bit bad_tap [256];
  bit oor_tap [256];
  int pulse_tap   = -1;
  int tap_m       = 0;
  int since_clear = 0;
  int incs = 0, decs = 0, loads = 0, overlaps = 0;
  bit hit;
  int lo, hi, oor_from;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {1'b0, lane.busy, lane.done, lane.fail, lane.delay_line_load, lane.delay_line_move,
            lane.delay_line_direction, lane.eye_monitor_clear_flags,
            lane.tap_left, lane.tap_right, lane.tap_center};
  endfunction

  // IOD model: tap follows load/move pulses, flags follow the programmed eye
  always @(negedge fab_clk) begin
    if (int'(lane.delay_line_load) + int'(lane.delay_line_move) + int'(lane.eye_monitor_clear_flags) > 1)
      overlaps++;
    if (lane.delay_line_load === 1'b1) begin
      tap_m = 0;
      loads++;
    end
    if (lane.delay_line_move === 1'b1) begin
      if (lane.delay_line_direction) begin
        tap_m++;
        incs++;
      end else begin
        tap_m--;
        decs++;
      end
    end
    if (lane.eye_monitor_clear_flags === 1'b1) since_clear = 0;
    else                                       since_clear++;
    lane.eye_monitor_early       = bad_tap[tap_m & 255] && (tap_m != pulse_tap);
    lane.eye_monitor_late        = (tap_m == pulse_tap) && (since_clear == SAMPLE_CYCLES_DEF);
    lane.delay_line_out_of_range = oor_tap[tap_m & 255];
  end

  task automatic set_window(input int l, input int h, input int oor_at);
    for (int t = 0; t < 256; t++) begin
      bad_tap[t] = !(t >= l && t <= h);
      oor_tap[t] = (oor_at >= 0) && (t >= oor_at);
    end
    pulse_tap = -1;
  endtask

  // Reference: window = first good tap up to the first bad one, truncated at range end
  task automatic model(output bit f, output int l, output int r, output int c,
                       output int inc, output int dec);
    int stop, b, e;
    stop = 255; b = -1; l = -1;
    for (int t = 0; t < 256; t++) if (oor_tap[t]) begin stop = t; break; end
    for (int t = 0; t <= stop; t++) if (!bad_tap[t]) begin l = t; break; end
    if (l < 0) begin
      f = 1'b1; l = 0; r = 0; c = 0; inc = stop; dec = 0;
      return;
    end
    for (int t = l + 1; t <= stop; t++) if (bad_tap[t]) begin b = t; break; end
    f = 1'b0;
    if (b >= 0) begin r = b - 1; e = b; end
    else        begin r = stop;  e = stop; end
    c = (l + r) / 2;
    inc = e;
    dec = e - c;
  endtask

  task automatic run_case(input string tag, input bit poke_start);
    bit ef;
    int el, er, ec, ei, ed;
    int cyc;
    bit fin;
    cyc = 0; fin = 1'b0;
    model(ef, el, er, ec, ei, ed);
    incs = 0; decs = 0; loads = 0; overlaps = 0;
    @(negedge fab_clk);
    lane.start = 1'b1;
    for (int n = 0; n < 20000 && !fin; n++) begin
      @(negedge fab_clk);
      lane.start = poke_start && (cyc == 100);
      if (lane.busy) cyc++;
      if (lane.done || lane.fail) fin = 1'b1;
    end
    lane.start = 1'b0;
    check({tag, "_finished"}, fin, 1);
    check({tag, "_done"}, lane.done, ef ? 0 : 1);
    check({tag, "_fail"}, lane.fail, ef ? 1 : 0);
    check({tag, "_left"}, lane.tap_left, el);
    check({tag, "_right"}, lane.tap_right, er);
    check({tag, "_center"}, lane.tap_center, ec);
    check({tag, "_inc_moves"}, incs, ei);
    check({tag, "_dec_moves"}, decs, ed);
    check({tag, "_loads"}, loads, 1);
    check({tag, "_pulse_overlap"}, overlaps, 0);
    check({tag, "_busy_cycles"}, cyc, (ei + 1) * TAP_COST + ed * BACK_COST);
    check({tag, "_iod_tap"}, tap_m, ei - ed);
    if (ei + ed > 0) check({tag, "_direction"}, lane.delay_line_direction, (ed > 0) ? 0 : 1);
    repeat (20) @(negedge fab_clk);
    check({tag, "_hold"}, {lane.busy, lane.done, lane.fail}, ef ? 1 : 2);
  endtask

  initial begin
    arst       = 1'b1;
    lane.start = 1'b0;
    repeat (3) @(negedge fab_clk);
    check("reset_outputs", outs(), 0);
    arst = 1'b0;
    repeat (2) @(negedge fab_clk);
    check("idle_outputs", outs(), 0);

    set_window(10, 40, -1);
    run_case("win10_40", 1'b1);
    check("win10_40_center_abs", lane.tap_center, 25);
    check("win10_40_decs_abs", decs, 16);

    set_window(1, 0, -1);
    run_case("all_bad", 1'b0);
    check("all_bad_incs_abs", incs, 255);

    set_window(200, 255, 220);
    run_case("oor220", 1'b0);
    check("oor220_center_abs", lane.tap_center, 210);

    set_window(5, 30, -1);
    bad_tap[12] = 1'b1;
    pulse_tap   = 12;
    run_case("late12", 1'b0);
    check("late12_right_abs", lane.tap_right, 11);
    check("late12_center_abs", lane.tap_center, 8);

    set_window(7, 8, -1);
    run_case("win7_8", 1'b0);
    check("win7_8_center_abs", lane.tap_center, 7);
    check("win7_8_decs_abs", decs, 2);

    // Reset in the middle of sampling tap 30, then retrain the same eye
    set_window(10, 40, -1);
    @(negedge fab_clk);
    lane.start = 1'b1;
    @(negedge fab_clk);
    lane.start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 5000 && !hit; n++) begin
      @(negedge fab_clk);
      if (tap_m == 30 && since_clear == 5) hit = 1'b1;
    end
    check("arst_reached_tap30", hit, 1);
    check("arst_pre_left", lane.tap_left, 10);
    check("arst_pre_busy", lane.busy, 1);
    #2 arst = 1'b1;
    #1;
    check("arst_async_outputs", outs(), 0);
    @(negedge fab_clk);
    arst = 1'b0;
    run_case("rearm", 1'b0);
    check("rearm_center_abs", lane.tap_center, 25);

    for (int k = 0; k < 4; k++) begin
      lo       = $urandom_range(0, 120);
      hi       = lo + $urandom_range(0, 40);
      oor_from = ($urandom_range(0, 2) == 0) ? lo + $urandom_range(1, 50) : -1;
      set_window(lo, hi, oor_from);
      run_case($sformatf("rand%0d", k), k[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
